// File: rtl/lookup_arbiter_if.sv
// rtl/lookup_arbiter_if.sv - requester, lookup-unit and status signals of lookup_arbiter
interface lookup_arbiter_if #(
    parameter int P_REQ_NUM = 4
);
    logic [P_REQ_NUM-1:0]    i_req_valid;
    logic [48*P_REQ_NUM-1:0] i_req_mac;
    logic [P_REQ_NUM-1:0]    o_req_ready;
    logic [47:0]             o_check_mac;
    logic [3:0]              o_check_id;
    logic                    o_check_valid;
    logic                    i_result_valid;
    logic [3:0]              i_result_id;
    logic [2:0]              i_outport;
    logic [1:0]              i_seek_flag;
    logic [P_REQ_NUM-1:0]    o_rsp_valid;
    logic [2:0]              o_rsp_outport;
    logic [1:0]              o_rsp_seek_flag;
    logic [P_REQ_NUM-1:0]    o_rsp_err;
    logic [3:0]              o_outstanding;
    logic [15:0]             o_stray_cnt;

    modport slave (
        input  i_req_valid, i_req_mac, i_result_valid, i_result_id, i_outport, i_seek_flag,
        output o_req_ready, o_check_mac, o_check_id, o_check_valid, o_rsp_valid,
               o_rsp_outport, o_rsp_seek_flag, o_rsp_err, o_outstanding, o_stray_cnt
    );

    modport master (
        output i_req_valid, i_req_mac, i_result_valid, i_result_id, i_outport, i_seek_flag,
        input  o_req_ready, o_check_mac, o_check_id, o_check_valid, o_rsp_valid,
               o_rsp_outport, o_rsp_seek_flag, o_rsp_err, o_outstanding, o_stray_cnt
    );
endinterface

// File: rtl/lookup_arbiter.sv
// rtl/lookup_arbiter.sv - round-robin sharing of the MAC lookup port with tagged result return
module lookup_arbiter #(
    parameter int P_REQ_NUM         = 4,
    parameter int P_MAX_OUTSTANDING = 2,
    parameter int P_TIMEOUT         = 16
) (
    input logic             i_clk,
    input logic             i_rst,
    lookup_arbiter_if.slave bus
);
    localparam int W_PTR = (P_REQ_NUM > 1) ? $clog2(P_REQ_NUM) : 1;
    localparam int W_TMO = $clog2(P_TIMEOUT);
    localparam logic [3:0]       MAX_OUT  = 4'(P_MAX_OUTSTANDING);
    localparam logic [W_TMO-1:0] TMO_LAST = W_TMO'(P_TIMEOUT - 1);
    localparam logic [W_PTR-1:0] PTR_LAST = W_PTR'(P_REQ_NUM - 1);

    typedef enum logic {ST_IDLE, ST_PEND} req_state_t;

    req_state_t           state   [P_REQ_NUM];
    logic [W_TMO-1:0]     tmo_cnt [P_REQ_NUM];
    logic [W_PTR-1:0]     rr_ptr;
    logic [3:0]           outstanding;
    logic [15:0]          stray_cnt;
    logic                 check_valid;
    logic [47:0]          check_mac;
    logic [3:0]           check_id;
    logic [P_REQ_NUM-1:0] rsp_valid;
    logic [2:0]           rsp_outport;
    logic [1:0]           rsp_seek_flag;
    logic [P_REQ_NUM-1:0] rsp_err;

    logic [P_REQ_NUM-1:0] eligible;
    logic [P_REQ_NUM-1:0] grant;
    logic                 grant_any;
    logic [W_PTR-1:0]     grant_idx;
    logic [W_PTR-1:0]     cand;
    int                   scan_idx;
    logic [P_REQ_NUM-1:0] res_hit;
    logic [P_REQ_NUM-1:0] tmo_hit;
    logic                 res_stray;
    logic [3:0]           n_done;

    // Grant scan starts at rr_ptr and wraps; the cap uses the registered count,
    // so a slot freed this cycle is only reusable from the next cycle on.
    always_comb begin
        eligible  = '0;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        scan_idx  = 0;
        for (int k = 0; k < P_REQ_NUM; k++)
            eligible[k] = bus.i_req_valid[k] && (state[k] == ST_IDLE);
        if (!i_rst && (outstanding < MAX_OUT)) begin
            for (int i = 0; i < P_REQ_NUM; i++) begin
                scan_idx = int'(rr_ptr) + i;
                if (scan_idx >= P_REQ_NUM)
                    scan_idx = scan_idx - P_REQ_NUM;
                cand = W_PTR'(scan_idx);
                if (!grant_any && eligible[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        grant[grant_idx] = grant_any;
    end

    // A result beats a timeout for the same requester in the same cycle.
    always_comb begin
        res_hit = '0;
        tmo_hit = '0;
        n_done  = '0;
        for (int k = 0; k < P_REQ_NUM; k++) begin
            res_hit[k] = bus.i_result_valid && (bus.i_result_id == 4'(k + 1)) && (state[k] == ST_PEND);
            tmo_hit[k] = (state[k] == ST_PEND) && (tmo_cnt[k] == TMO_LAST) && !res_hit[k];
            n_done     = n_done + 4'(res_hit[k]) + 4'(tmo_hit[k]);
        end
        res_stray = bus.i_result_valid && (res_hit == '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < P_REQ_NUM; k++) begin
                state[k]   <= ST_IDLE;
                tmo_cnt[k] <= '0;
            end
            rr_ptr        <= '0;
            outstanding   <= '0;
            stray_cnt     <= '0;
            check_valid   <= 1'b0;
            check_mac     <= '0;
            check_id      <= '0;
            rsp_valid     <= '0;
            rsp_outport   <= '0;
            rsp_seek_flag <= '0;
            rsp_err       <= '0;
        end else begin
            check_valid <= grant_any;
            if (grant_any) begin
                check_mac <= bus.i_req_mac[48*int'(grant_idx) +: 48];
                check_id  <= 4'(grant_idx) + 4'd1;
                rr_ptr    <= (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
            end
            for (int k = 0; k < P_REQ_NUM; k++) begin
                if (grant[k]) begin
                    state[k]   <= ST_PEND;
                    tmo_cnt[k] <= '0;
                end else if (res_hit[k] || tmo_hit[k]) begin
                    state[k] <= ST_IDLE;
                end else if (state[k] == ST_PEND) begin
                    tmo_cnt[k] <= tmo_cnt[k] + 1'b1;
                end
            end
            rsp_valid <= res_hit;
            rsp_err   <= tmo_hit;
            if (res_hit != '0) begin
                rsp_outport   <= bus.i_outport;
                rsp_seek_flag <= bus.i_seek_flag;
            end
            outstanding <= outstanding + {3'b000, grant_any} - n_done;
            if (res_stray && (stray_cnt != 16'hFFFF))
                stray_cnt <= stray_cnt + 16'd1;
        end
    end

    assign bus.o_req_ready     = grant;
    assign bus.o_check_valid   = check_valid;
    assign bus.o_check_mac     = check_mac;
    assign bus.o_check_id      = check_id;
    assign bus.o_rsp_valid     = rsp_valid;
    assign bus.o_rsp_outport   = rsp_outport;
    assign bus.o_rsp_seek_flag = rsp_seek_flag;
    assign bus.o_rsp_err       = rsp_err;
    assign bus.o_outstanding   = outstanding;
    assign bus.o_stray_cnt     = stray_cnt;
endmodule

// File: tb/tb_lookup_arbiter.sv
// tb/tb_lookup_arbiter.sv - self-checking bench for lookup_arbiter
module tb_lookup_arbiter;
    localparam int N   = 4;
    localparam int CAP = 2;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lookup_arbiter_if #(.P_REQ_NUM(N)) bus ();

    lookup_arbiter #(
        .P_REQ_NUM(N),
        .P_MAX_OUTSTANDING(CAP),
        .P_TIMEOUT(TMO)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    logic [47:0] mac_of [N];

    typedef struct {
        logic [3:0]  valid;
        logic        rv;
        logic [3:0]  rid;
        logic [3:0]  ready;
        logic        cv;
        logic [3:0]  cid;
        logic [3:0]  rsp;
        logic [3:0]  outs;
        logic [15:0] stray;
    } vec_t;
    vec_t vt [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.i_req_valid    = '0;
        bus.i_result_valid = 1'b0;
        bus.i_result_id    = '0;
        bus.i_outport      = '0;
        bus.i_seek_flag    = '0;
        for (int k = 0; k < N; k++) bus.i_req_mac[48*k +: 48] = mac_of[k];
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " ready"}, bus.o_req_ready, 0);
        chk({tag, " check_valid"}, bus.o_check_valid, 0);
        chk({tag, " check_id"}, bus.o_check_id, 0);
        chk({tag, " check_mac"}, bus.o_check_mac, 0);
        chk({tag, " rsp_valid"}, bus.o_rsp_valid, 0);
        chk({tag, " rsp_outport"}, bus.o_rsp_outport, 0);
        chk({tag, " rsp_seek"}, bus.o_rsp_seek_flag, 0);
        chk({tag, " rsp_err"}, bus.o_rsp_err, 0);
        chk({tag, " outstanding"}, bus.o_outstanding, 0);
        chk({tag, " stray"}, bus.o_stray_cnt, 0);
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_random(input int cycles);
        int rr, now, g, hit, k, cnt, res_pct, rid;
        logic [15:0] m_stray;
        logic        exp_cv;
        logic [3:0]  exp_cid, exp_rsp, exp_err, exp_ready;
        logic [47:0] exp_mac;
        logic [2:0]  exp_op;
        logic [1:0]  exp_sf;
        logic [47:0] cur_mac [N];
        bit          pend [N];
        int          since [N];
        rr = 0; now = 0; m_stray = '0; res_pct = 5;
        exp_cv = 1'b0; exp_cid = '0; exp_mac = '0; exp_rsp = '0; exp_err = '0;
        exp_op = '0; exp_sf = '0;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; since[i] = 0; end
        for (int cyc = 0; cyc < cycles; cyc++) begin
            cnt = 0;
            for (int i = 0; i < N; i++) if (pend[i]) cnt++;
            chk("rnd check_valid", bus.o_check_valid, exp_cv);
            chk("rnd check_id", bus.o_check_id, exp_cid);
            chk("rnd check_mac", bus.o_check_mac, exp_mac);
            chk("rnd rsp_valid", bus.o_rsp_valid, exp_rsp);
            chk("rnd rsp_err", bus.o_rsp_err, exp_err);
            chk("rnd outstanding", bus.o_outstanding, cnt);
            chk("rnd stray", bus.o_stray_cnt, m_stray);
            if (exp_rsp != 0) begin
                chk("rnd rsp_outport", bus.o_rsp_outport, exp_op);
                chk("rnd rsp_seek", bus.o_rsp_seek_flag, exp_sf);
            end
            case ((cyc / 200) % 3)
                0: res_pct = 5;
                1: res_pct = 35;
                default: res_pct = 80;
            endcase
            for (int i = 0; i < N; i++) begin
                cur_mac[i] = {16'($urandom), 32'($urandom)};
                bus.i_req_mac[48*i +: 48] = cur_mac[i];
                bus.i_req_valid[i] = ($urandom_range(0, 9) < 7);
            end
            bus.i_result_valid = ($urandom_range(0, 99) < res_pct);
            rid = ($urandom_range(0, 3) != 0) ? $urandom_range(1, N) : $urandom_range(0, 15);
            bus.i_result_id = 4'(rid);
            bus.i_outport   = 3'($urandom);
            bus.i_seek_flag = 2'($urandom);
            #1;
            g = -1;
            if (cnt < CAP)
                for (int i = 0; i < N; i++) begin
                    k = (rr + i) % N;
                    if (g < 0 && bus.i_req_valid[k] && !pend[k]) g = k;
                end
            exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
            chk("rnd ready", bus.o_req_ready, exp_ready);
            hit = -1;
            if (bus.i_result_valid) begin
                if (rid >= 1 && rid <= N && pend[rid-1]) hit = rid - 1;
                else if (m_stray != 16'hFFFF) m_stray++;
            end
            exp_err = '0;
            for (int i = 0; i < N; i++)
                if (pend[i] && (now - since[i] == TMO - 1) && i != hit) exp_err[i] = 1'b1;
            exp_rsp = (hit >= 0) ? 4'(1 << hit) : 4'b0000;
            if (hit >= 0) begin
                exp_op = bus.i_outport;
                exp_sf = bus.i_seek_flag;
                pend[hit] = 1'b0;
            end
            for (int i = 0; i < N; i++) if (exp_err[i]) pend[i] = 1'b0;
            exp_cv = (g >= 0);
            if (g >= 0) begin
                exp_cid   = 4'(g + 1);
                exp_mac   = cur_mac[g];
                pend[g]   = 1'b1;
                since[g]  = now + 1;
                rr        = (g + 1) % N;
            end
            now++;
            @(negedge clk);
        end
        drive_idle();
    endtask

    initial begin
        for (int k = 0; k < N; k++) mac_of[k] = 48'h0A0B0C0D0E00 + 48'(k * 17);
        vt[0]  = '{4'hF, 1'b0, 4'd0, 4'b0001, 1'b1, 4'd1, 4'b0000, 4'd1, 16'd0};
        vt[1]  = '{4'hF, 1'b0, 4'd0, 4'b0010, 1'b1, 4'd2, 4'b0000, 4'd2, 16'd0};
        vt[2]  = '{4'hF, 1'b0, 4'd0, 4'b0000, 1'b0, 4'd2, 4'b0000, 4'd2, 16'd0};
        vt[3]  = '{4'hF, 1'b1, 4'd1, 4'b0000, 1'b0, 4'd2, 4'b0001, 4'd1, 16'd0};
        vt[4]  = '{4'hF, 1'b1, 4'd2, 4'b0100, 1'b1, 4'd3, 4'b0010, 4'd1, 16'd0};
        vt[5]  = '{4'hF, 1'b0, 4'd0, 4'b1000, 1'b1, 4'd4, 4'b0000, 4'd2, 16'd0};
        vt[6]  = '{4'hF, 1'b0, 4'd0, 4'b0000, 1'b0, 4'd4, 4'b0000, 4'd2, 16'd0};
        vt[7]  = '{4'hF, 1'b1, 4'd3, 4'b0000, 1'b0, 4'd4, 4'b0100, 4'd1, 16'd0};
        vt[8]  = '{4'hF, 1'b1, 4'd4, 4'b0001, 1'b1, 4'd1, 4'b1000, 4'd1, 16'd0};
        vt[9]  = '{4'h0, 1'b1, 4'd0, 4'b0000, 1'b0, 4'd1, 4'b0000, 4'd1, 16'd1};
        vt[10] = '{4'h0, 1'b1, 4'd9, 4'b0000, 1'b0, 4'd1, 4'b0000, 4'd1, 16'd2};
        vt[11] = '{4'h0, 1'b1, 4'd2, 4'b0000, 1'b0, 4'd1, 4'b0000, 4'd1, 16'd3};
        vt[12] = '{4'h0, 1'b1, 4'd1, 4'b0000, 1'b0, 4'd1, 4'b0001, 4'd0, 16'd3};

        @(negedge clk);
        do_reset();
        for (int i = 0; i < 13; i++) begin
            bus.i_req_valid    = vt[i].valid;
            bus.i_result_valid = vt[i].rv;
            bus.i_result_id    = vt[i].rid;
            #1;
            chk($sformatf("vec%0d ready", i), bus.o_req_ready, vt[i].ready);
            @(negedge clk);
            chk($sformatf("vec%0d check_valid", i), bus.o_check_valid, vt[i].cv);
            chk($sformatf("vec%0d check_id", i), bus.o_check_id, vt[i].cid);
            chk($sformatf("vec%0d check_mac", i), bus.o_check_mac, mac_of[vt[i].cid - 1]);
            chk($sformatf("vec%0d rsp_valid", i), bus.o_rsp_valid, vt[i].rsp);
            chk($sformatf("vec%0d outstanding", i), bus.o_outstanding, vt[i].outs);
            chk($sformatf("vec%0d stray", i), bus.o_stray_cnt, vt[i].stray);
        end
        drive_idle();

        // single request from requester 2
        do_reset();
        bus.i_req_mac[48*2 +: 48] = 48'h8DBC5C4A0301;
        bus.i_req_valid = 4'b0100;
        #1 chk("single ready", bus.o_req_ready, 4'b0100);
        @(negedge clk);
        bus.i_req_valid = '0;
        chk("single check_valid", bus.o_check_valid, 1);
        chk("single check_id", bus.o_check_id, 3);
        chk("single check_mac", bus.o_check_mac, 48'h8DBC5C4A0301);
        bus.i_result_valid = 1'b1; bus.i_result_id = 4'd3; bus.i_outport = 3'd3; bus.i_seek_flag = 2'd0;
        @(negedge clk);
        drive_idle();
        chk("single rsp_valid", bus.o_rsp_valid, 4'b0100);
        chk("single rsp_outport", bus.o_rsp_outport, 3);
        chk("single rsp_seek", bus.o_rsp_seek_flag, 0);
        chk("single outstanding", bus.o_outstanding, 0);
        @(negedge clk);
        chk("single rsp one cycle", bus.o_rsp_valid, 0);

        // timeout of requester 1, then re-grant and a late stray result
        do_reset();
        bus.i_req_valid = 4'b0010;
        #1 chk("tmo ready", bus.o_req_ready, 4'b0010);
        @(negedge clk);
        bus.i_req_valid = '0;
        chk("tmo issue id", bus.o_check_id, 2);
        for (int i = 1; i < TMO; i++) begin
            @(negedge clk);
            chk($sformatf("tmo quiet %0d", i), bus.o_rsp_err, 0);
        end
        @(negedge clk);
        chk("tmo err", bus.o_rsp_err, 4'b0010);
        chk("tmo outstanding", bus.o_outstanding, 0);
        bus.i_req_valid = 4'b0010; bus.i_result_valid = 1'b1; bus.i_result_id = 4'd2;
        #1 chk("tmo regrant ready", bus.o_req_ready, 4'b0010);
        @(negedge clk);
        drive_idle();
        chk("tmo err one cycle", bus.o_rsp_err, 0);
        chk("tmo late stray", bus.o_stray_cnt, 1);
        chk("tmo late no rsp", bus.o_rsp_valid, 0);
        chk("tmo regrant issue", bus.o_check_valid, 1);

        // result arrives in the last cycle before timeout
        do_reset();
        bus.i_req_valid = 4'b0001;
        @(negedge clk);
        bus.i_req_valid = '0;
        repeat (TMO - 1) @(negedge clk);
        chk("race no early err", bus.o_rsp_err, 0);
        bus.i_result_valid = 1'b1; bus.i_result_id = 4'd1; bus.i_outport = 3'd5; bus.i_seek_flag = 2'd2;
        @(negedge clk);
        drive_idle();
        chk("race rsp_valid", bus.o_rsp_valid, 4'b0001);
        chk("race err", bus.o_rsp_err, 0);
        chk("race outstanding", bus.o_outstanding, 0);
        chk("race rsp_outport", bus.o_rsp_outport, 5);
        chk("race rsp_seek", bus.o_rsp_seek_flag, 2);
        @(negedge clk);
        chk("race err after", bus.o_rsp_err, 0);

        // asynchronous reset with two lookups in flight
        do_reset();
        bus.i_req_valid = 4'b0011;
        @(negedge clk);
        bus.i_result_valid = 1'b1; bus.i_result_id = 4'd9;
        @(negedge clk);
        bus.i_result_valid = 1'b0;
        chk("midrst outstanding before", bus.o_outstanding, 2);
        chk("midrst stray before", bus.o_stray_cnt, 1);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        bus.i_req_valid = 4'hF; bus.i_result_valid = 1'b1; bus.i_result_id = 4'd1;
        #1 chk("midrst first grant", bus.o_req_ready, 4'b0001);
        @(negedge clk);
        drive_idle();
        chk("midrst old tag stray", bus.o_stray_cnt, 1);
        chk("midrst no rsp", bus.o_rsp_valid, 0);
        chk("midrst issue id", bus.o_check_id, 1);

        do_reset();
        run_random(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
